// File: rtl/gbar_unit.sv
// Global barrier unit: tracks per-barrier arrival masks for all cores and
// emits a one-cycle release pulse when the last expected core arrives.
// Ports: clk, reset_n (async, active-low); req_valid/req_id/req_size_m1/
// req_core_id/req_ready request channel; rsp_valid/rsp_id release pulse;
// err (sticky protocol error), busy (any barrier pending, registered).
// Optional: define GBAR_PERF_EN to add perf_releases and perf_wait_cycles.
module gbar_unit #(
  parameter  int NUM_BARRIERS = 16,
  parameter  int NUM_CORES    = 8,
  localparam int ID_W         = $clog2(NUM_BARRIERS),
  localparam int CORE_W       = $clog2(NUM_CORES),
  localparam int SIZE_W       = CORE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [ID_W-1:0]   req_id,
  input  logic [SIZE_W-1:0] req_size_m1,
  input  logic [CORE_W-1:0] req_core_id,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic              err,
  output logic              busy
`ifdef GBAR_PERF_EN
  ,
  output logic [31:0]       perf_releases,
  output logic [31:0]       perf_wait_cycles
`endif
);

  localparam int CNT_W = SIZE_W + 1;

  logic [NUM_CORES-1:0]    mask_q [NUM_BARRIERS];
  logic [NUM_CORES-1:0]    mask_d [NUM_BARRIERS];
  logic [CNT_W-1:0]        cnt_q  [NUM_BARRIERS];
  logic [CNT_W-1:0]        cnt_d  [NUM_BARRIERS];
  logic [SIZE_W-1:0]       size_q [NUM_BARRIERS];
  logic [SIZE_W-1:0]       size_d [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] active_q, active_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]         rsp_id_q, rsp_id_d;

  logic                    acc;
  logic                    bad_core;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [CNT_W-1:0]        target;

  assign req_ready = reset_n;
  assign acc       = req_valid && req_ready;
  assign bad_core  = {1'b0, req_core_id} >= CNT_W'(NUM_CORES);

  // Post-update count and release threshold for the addressed slot.
  assign cnt_nxt = cnt_q[req_id] + CNT_W'(1);
  assign target  = {1'b0, size_q[req_id]} + CNT_W'(1);

  always_comb begin
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    active_d    = active_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    if (acc) begin
      if (bad_core) begin
        err_d = 1'b1;
      end else if (!active_q[req_id]) begin
        size_d[req_id] = req_size_m1;
        if (req_size_m1 == '0) begin
          // Lone participant: release without arming.
          rsp_valid_d = 1'b1;
          rsp_id_d    = req_id;
        end else begin
          active_d[req_id] = 1'b1;
          mask_d[req_id]   = NUM_CORES'(1) << req_core_id;
          cnt_d[req_id]    = CNT_W'(1);
        end
      end else if (mask_q[req_id][req_core_id]) begin
        err_d = 1'b1;
      end else begin
        // A size mismatch is flagged but counted against the latched size.
        if (req_size_m1 != size_q[req_id]) err_d = 1'b1;
        if (cnt_nxt == target) begin
          mask_d[req_id]   = '0;
          cnt_d[req_id]    = '0;
          active_d[req_id] = 1'b0;
          rsp_valid_d      = 1'b1;
          rsp_id_d         = req_id;
        end else begin
          mask_d[req_id][req_core_id] = 1'b1;
          cnt_d[req_id]               = cnt_nxt;
        end
      end
    end
    busy_d = |active_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BARRIERS; i++) begin
        mask_q[i] <= '0;
        cnt_q[i]  <= '0;
        size_q[i] <= '0;
      end
      active_q    <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      active_q    <= active_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign err       = err_q;
  assign busy      = busy_q;

`ifdef GBAR_PERF_EN
  logic [31:0] perf_rel_q, perf_rel_d;
  logic [31:0] perf_wait_q, perf_wait_d;
  logic [31:0] act_cnt;

  always_comb begin
    act_cnt = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      act_cnt = act_cnt + 32'(active_q[i]);
    end
    perf_rel_d  = perf_rel_q + 32'(rsp_valid_q);
    perf_wait_d = perf_wait_q + act_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_rel_q  <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_rel_q  <= perf_rel_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_releases    = perf_rel_q;
  assign perf_wait_cycles = perf_wait_q;
`endif

endmodule

// File: tb/tb_gbar_unit.sv
// Randomized self-checking bench for gbar_unit against a set-based
// barrier model (arrived-core sets, latched sizes, sticky error).
module tb_gbar_unit;

  localparam int NB = 16;
  localparam int NC = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_id = '0;
  logic [2:0] req_size_m1 = '0;
  logic [2:0] req_core_id = '0;
  logic       req_ready;
  logic       rsp_valid;
  logic [3:0] rsp_id;
  logic       err;
  logic       busy;
`ifdef GBAR_PERF_EN
  logic [31:0] perf_releases;
  logic [31:0] perf_wait_cycles;
  int unsigned e_rel, e_wait;
`endif

  gbar_unit #(.NUM_BARRIERS(NB), .NUM_CORES(NC)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_id(req_id),
    .req_size_m1(req_size_m1),
    .req_core_id(req_core_id),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .err(err),
    .busy(busy)
`ifdef GBAR_PERF_EN
    ,
    .perf_releases(perf_releases),
    .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  bit m_act [NB];
  int m_size [NB];
  bit m_seen [NB][NC];
  bit e_rsp;
  int e_rid;
  bit e_err;
  int tsz [NB];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int arrived(int b);
    int n = 0;
    for (int c = 0; c < NC; c++) n += int'(m_seen[b][c]);
    return n;
  endfunction

  function automatic bit any_active();
    for (int b = 0; b < NB; b++) if (m_act[b]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int n_active();
    int n = 0;
    for (int b = 0; b < NB; b++) n += int'(m_act[b]);
    return n;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_act[b] = 1'b0;
      m_size[b] = 0;
      for (int c = 0; c < NC; c++) m_seen[b][c] = 1'b0;
    end
    e_rsp = 1'b0;
    e_rid = 0;
    e_err = 1'b0;
`ifdef GBAR_PERF_EN
    e_rel = 0;
    e_wait = 0;
`endif
  endtask

  task automatic model(bit v, int id, int sz, int core);
`ifdef GBAR_PERF_EN
    e_rel += int'(e_rsp);
    e_wait += n_active();
`endif
    e_rsp = 1'b0;
    if (!v) return;
    if (core >= NC) begin
      e_err = 1'b1;
    end else if (!m_act[id]) begin
      if (sz == 0) begin
        e_rsp = 1'b1;
        e_rid = id;
      end else begin
        m_act[id] = 1'b1;
        m_size[id] = sz;
        m_seen[id][core] = 1'b1;
      end
    end else if (m_seen[id][core]) begin
      e_err = 1'b1;
    end else begin
      if (sz != m_size[id]) e_err = 1'b1;
      m_seen[id][core] = 1'b1;
      if (arrived(id) == m_size[id] + 1) begin
        e_rsp = 1'b1;
        e_rid = id;
        m_act[id] = 1'b0;
        for (int c = 0; c < NC; c++) m_seen[id][c] = 1'b0;
      end
    end
  endtask

  task automatic step(bit v, int id, int sz, int core);
    @(negedge clk);
    req_valid = v;
    req_id = 4'(id);
    req_size_m1 = 3'(sz);
    req_core_id = 3'(core);
    @(posedge clk);
    model(v, id, sz, core);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    if (e_rsp) chk("rsp_id", 32'(rsp_id), 32'(e_rid));
    chk("err", 32'(err), 32'(e_err));
    chk("busy", 32'(busy), 32'(any_active()));
    chk("req_ready", 32'(req_ready), 32'd1);
`ifdef GBAR_PERF_EN
    chk("perf_releases", perf_releases, e_rel);
    chk("perf_wait", perf_wait_cycles, e_wait);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    // One idle edge passes before the next step drives inputs.
    @(posedge clk);
    model(1'b0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Basic release: cores 0..3 at id 5, size_m1=3.
    for (int c = 0; c < 4; c++) step(1'b1, 5, 3, c);
    step(1'b0, 0, 0, 0);
    step(1'b0, 0, 0, 0);

    // Single participant.
    step(1'b1, 2, 0, 7);
    step(1'b0, 0, 0, 0);

    // Interleaved ids 0 and 15, id 0 re-armed right after release.
    step(1'b1, 0, 1, 0);
    step(1'b1, 15, 1, 3);
    step(1'b1, 0, 1, 1);
    step(1'b1, 0, 1, 2);
    step(1'b1, 15, 1, 4);
    step(1'b1, 0, 1, 5);
    step(1'b0, 0, 0, 0);

    // Duplicate arrival, then the real partner.
    step(1'b1, 3, 1, 1);
    step(1'b1, 3, 1, 1);
    step(1'b1, 3, 1, 0);
    step(1'b0, 0, 0, 0);

    // Size mismatch is flagged but still counted.
    step(1'b1, 4, 2, 0);
    step(1'b1, 4, 5, 1);
    step(1'b1, 4, 2, 2);

    // Reset mid-operation: episode at id 9 discarded.
    do_reset();
    for (int c = 0; c < 3; c++) step(1'b1, 9, 3, c);
    do_reset();
    step(1'b1, 9, 3, 3);
    step(1'b1, 9, 3, 0);
    step(1'b1, 9, 3, 1);
    step(1'b1, 9, 3, 2);
    step(1'b0, 0, 0, 0);

    // Random traffic with mostly consistent per-barrier sizes.
    do_reset();
    for (int b = 0; b < NB; b++) tsz[b] = $urandom_range(0, 7);
    for (int i = 0; i < 3000; i++) begin
      int id;
      int sz;
      bit v;
      v = ($urandom_range(0, 9) < 8);
      id = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NB - 1)
                                       : $urandom_range(0, 3);
      sz = ($urandom_range(0, 31) == 0) ? $urandom_range(0, 7) : tsz[id];
      step(v, id, sz, $urandom_range(0, NC - 1));
      if (i % 500 == 499) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
